// File: rtl/button_pio_pkg.sv
// Shared constants for the debounced button PIO: register addresses and edge-detect modes.
package button_pio_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_RAW  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_MODE = 3'd4;

    localparam logic [1:0] MODE_RISE  = 2'd0;
    localparam logic [1:0] MODE_FALL  = 2'd1;
    localparam logic [1:0] MODE_BOTH  = 2'd2;
    localparam logic [1:0] MODE_LEVEL = 2'd3;

    // Per-bit detect selection for the current edge mode.
    function automatic logic det_sel(logic [1:0] mode, logic rise, logic fall, logic level);
        logic det;
        unique case (mode)
            MODE_RISE: det = rise;
            MODE_FALL: det = fall;
            MODE_BOTH: det = rise | fall;
            default:   det = level;
        endcase
        return det;
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-FF synchroniser followed by a hold-time counter that only
// accepts a new level after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module pio_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= din;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any return to the accepted level restarts the hold window.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign sync   = sync_q;
    assign stable = stable_q;

endmodule

// File: rtl/button_pio_dbnc.sv
// Avalon-MM button/switch PIO with per-bit debouncing, selectable edge detection,
// write-1-to-clear edge capture and a masked interrupt output.
module button_pio_dbnc
    import button_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_MODE_RST   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0]  MODE_RST_VAL = 2'(EDGE_MODE_RST);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_prev_q;
    logic [WIDTH-1:0] rise, fall, det;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] clr;
    logic [1:0]       edge_mode_q, edge_mode_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .sync   (sync[i]),
            .stable (stable[i])
        );
    end

    assign wr_en        = chipselect & ~write_n;
    assign rise         = stable & ~stable_prev_q;
    assign fall         = ~stable & stable_prev_q;
    assign unused_wdata = ^writedata;

    always_comb begin
        det = '0;
        for (int i = 0; i < WIDTH; i++) begin
            det[i] = det_sel(edge_mode_q, rise[i], fall[i], stable[i]);
        end
    end

    // Set wins over clear; in level mode an asserted input cannot be acknowledged away.
    always_comb begin
        clr = '0;
        if (wr_en && address == ADDR_EDGE) begin
            clr = writedata[WIDTH-1:0];
        end
        if (edge_mode_q == MODE_LEVEL) begin
            clr = clr & ~stable;
        end
        edge_cap_d = det | (edge_cap_q & ~clr);
    end

    always_comb begin
        irq_mask_d  = irq_mask_q;
        edge_mode_d = edge_mode_q;
        if (wr_en && address == ADDR_MASK) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_MODE) begin
            edge_mode_d = writedata[1:0];
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d = 32'(stable);
            ADDR_RAW:  readdata_d = 32'(sync);
            ADDR_MASK: readdata_d = 32'(irq_mask_q);
            ADDR_EDGE: readdata_d = 32'(edge_cap_q);
            ADDR_MODE: readdata_d = 32'(edge_mode_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_prev_q <= '0;
            irq_mask_q    <= '0;
            edge_cap_q    <= '0;
            edge_mode_q   <= MODE_RST_VAL;
            readdata_q    <= '0;
        end else begin
            stable_prev_q <= stable;
            irq_mask_q    <= irq_mask_d;
            edge_cap_q    <= edge_cap_d;
            edge_mode_q   <= edge_mode_d;
            readdata_q    <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_button_pio_dbnc.sv
// Scoreboard bench: drivers queue expected read/irq values, a negedge monitor pops and compares.
module tb_button_pio_dbnc;
    import button_pio_pkg::*;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned DBNC     = 4;
    localparam int unsigned MODE_RST = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port = '0;
    logic             irq;

    button_pio_dbnc #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DBNC),
        .EDGE_MODE_RST  (MODE_RST)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t rd_q[$];
    exp_t irq_q[$];
    logic rd_req = 1'b0, irq_req = 1'b0;
    logic rd_vld = 1'b0, irq_vld = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [9:0] pat;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    always @(posedge clk) begin
        rd_vld  <= rd_req;
        irq_vld <= irq_req;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_underflow: got readdata 0x%0h, expected no read", readdata);
            end else begin
                e = rd_q.pop_front();
                check(e.name, readdata, e.exp);
            end
        end
        if (irq_vld) begin
            if (irq_q.size() == 0) begin
                n_checks++;
                $display("FAIL irq_underflow: got irq %0b, expected no sample", irq);
            end else begin
                e = irq_q.pop_front();
                check(e.name, {31'b0, irq}, e.exp);
            end
        end
    end

    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd_req     = 1'b0;
        irq_req    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_idle();
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        bus_idle();
        address = a;
        rd_req  = 1'b1;
        rd_q.push_back('{nm, exp});
    endtask

    // Piggybacks on the current cycle; irq is sampled one cycle later.
    task automatic chk_irq(input logic exp, input string nm);
        irq_req = 1'b1;
        irq_q.push_back('{nm, {31'b0, exp}});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_idle();
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        // 1: reset state
        idle(2);
        rd(ADDR_MASK, 32'h0, "rst_hold_readdata");
        chk_irq(1'b0, "rst_hold_irq");
        @(negedge clk);
        bus_idle();
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), (a == 4) ? 32'(MODE_RST) : 32'h0, $sformatf("t1_read_addr%0d", a));
            chk_irq(1'b0, "t1_irq");
        end

        // 2: debounce latency and capture
        wr(ADDR_MODE, 32'(MODE_RISE));
        wr(ADDR_MASK, 32'h1);
        for (int i = 0; i < 6; i++) begin
            rd(ADDR_DATA, 32'h0, "t2_data_before_accept");
            if (i == 0) in_port[0] = 1'b1;
            chk_irq(1'b0, "t2_irq_before");
        end
        rd(ADDR_DATA, 32'h1, "t2_data_accept");
        chk_irq(1'b1, "t2_irq_after");
        rd(ADDR_EDGE, 32'h1, "t2_edge");
        wr(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE, 32'h0, "t2_edge_cleared");

        // 3: bounce rejection on bit 1, raw shows the toggles two cycles late
        pat = 10'b0001110111;
        for (int j = 0; j < 10; j++) begin
            rd(ADDR_RAW, {28'b0, 2'b00, (j >= 2) ? pat[j-2] : 1'b0, 1'b1}, $sformatf("t3_raw_%0d", j));
            in_port[1] = pat[j];
        end
        idle(8);
        rd(ADDR_DATA, 32'h1, "t3_data_unchanged");
        rd(ADDR_EDGE, 32'h0, "t3_edge_none");

        // 4: falling mode, then both mode
        wr(ADDR_MODE, 32'(MODE_FALL));
        @(negedge clk);
        bus_idle();
        in_port[2] = 1'b1;
        idle(10);
        rd(ADDR_DATA, 32'h5, "t4_data_bit2_high");
        rd(ADDR_EDGE, 32'h0, "t4_fall_ignores_rise");
        @(negedge clk);
        bus_idle();
        in_port[2] = 1'b0;
        idle(10);
        rd(ADDR_EDGE, 32'h4, "t4_fall_capture");
        wr(ADDR_EDGE, 32'h4);
        rd(ADDR_MODE, 32'(MODE_FALL), "t4_mode_readback");
        wr(ADDR_MODE, 32'(MODE_BOTH));
        @(negedge clk);
        bus_idle();
        in_port[3] = 1'b1;
        idle(7);
        rd(ADDR_EDGE, 32'h8, "t4_both_rise");
        wr(ADDR_EDGE, 32'h8);
        rd(ADDR_EDGE, 32'h0, "t4_both_cleared");
        in_port[3] = 1'b0;
        idle(8);
        rd(ADDR_EDGE, 32'h8, "t4_both_fall");
        wr(ADDR_EDGE, 32'h8);

        // 5: set beats W1C in the same cycle
        @(negedge clk);
        bus_idle();
        in_port[2] = 1'b1;
        idle(10);
        @(negedge clk);
        bus_idle();
        in_port[0] = 1'b0;
        idle(10);
        rd(ADDR_EDGE, 32'h5, "t5_setup");
        wr(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE, 32'h4, "t5_partial_clear");
        chk_irq(1'b0, "t5_irq_masked");
        @(negedge clk);
        bus_idle();
        in_port[0] = 1'b1;
        idle(5);
        wr(ADDR_EDGE, 32'hF);
        rd(ADDR_EDGE, 32'h1, "t5_set_priority");
        chk_irq(1'b1, "t5_irq");
        wr(ADDR_EDGE, 32'h0);
        rd(ADDR_EDGE, 32'h1, "t5_w1c_zero");
        wr(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE, 32'h0, "t5_cleared");

        // 6: level mode
        wr(ADDR_MODE, 32'(MODE_RISE));
        @(negedge clk);
        bus_idle();
        in_port = '0;
        idle(10);
        rd(ADDR_DATA, 32'h0, "t6_all_low");
        rd(ADDR_EDGE, 32'h0, "t6_no_rise_on_fall");
        @(negedge clk);
        bus_idle();
        in_port[1] = 1'b1;
        idle(10);
        rd(ADDR_EDGE, 32'h2, "t6_rise_bit1");
        wr(ADDR_MODE, 32'(MODE_LEVEL));
        wr(ADDR_MASK, 32'h2);
        rd(ADDR_EDGE, 32'h2, "t6_mode_write_keeps");
        wr(ADDR_EDGE, 32'h2);
        rd(ADDR_EDGE, 32'h2, "t6_level_hold");
        chk_irq(1'b1, "t6_irq_level");
        @(negedge clk);
        bus_idle();
        in_port[1] = 1'b0;
        idle(10);
        rd(ADDR_DATA, 32'h0, "t6_released");
        rd(ADDR_EDGE, 32'h2, "t6_still_captured");
        wr(ADDR_EDGE, 32'h2);
        rd(ADDR_EDGE, 32'h0, "t6_level_cleared");
        chk_irq(1'b0, "t6_irq_dropped");

        // reset mid-count
        @(negedge clk);
        bus_idle();
        in_port[0] = 1'b1;
        idle(3);
        @(negedge clk);
        bus_idle();
        reset_n = 1'b0;
        rd(ADDR_MASK, 32'h0, "r_in_reset");
        chk_irq(1'b0, "r_irq_in_reset");
        @(negedge clk);
        bus_idle();
        reset_n = 1'b1;
        rd(ADDR_DATA, 32'h0, "r_data");
        rd(ADDR_MASK, 32'h0, "r_mask");
        rd(ADDR_MODE, 32'(MODE_RST), "r_mode");
        rd(ADDR_EDGE, 32'h0, "r_edge");
        chk_irq(1'b0, "r_irq");
        idle(6);
        rd(ADDR_DATA, 32'h1, "r_held_accept");
        rd(ADDR_EDGE, 32'h1, "r_held_rise");

        idle(3);
        n_checks++;
        if (rd_q.size() == 0 && irq_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d/%0d pending, expected 0/0", rd_q.size(), irq_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
